uart_rx_frame_controller: RTL

Sequences the uart_receiver byte handshake and turns its byte stream into checked frames of the form sync, length, payload, checksum. Payload bytes are buffered until the checksum passes, then drained to the downstream consumer over a valid/ready interface with a last marker. While the controller is full or draining, it withholds `rx_byte_done`, so the receiver's clear-to-send throttles the remote sender.

---
 rtl/uart_rx_frame_controller.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/uart_rx_frame_controller.sv
// Frame controller behind a UART receiver: hunts for sync, checks length and checksum,
// buffers the payload and drains it over valid/ready while holding off further bytes.
module uart_rx_frame_controller #(
   parameter int         MaxPayload    = 16,
   parameter int         TimeoutClocks = 1024,
   parameter logic [7:0] SyncByte      = 8'hA5
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] rx_byte_in,
   input  logic       rx_byte_valid_in,
   output logic       rx_byte_done_out,
   output logic [7:0] out_byte,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       out_last,
   output logic       frame_ok_out,
   output logic       frame_error_out,
   output logic [1:0] error_code_out,
   output logic       busy_out
);
   localparam int AW = (MaxPayload > 1) ? $clog2(MaxPayload) : 1;
   localparam int TW = $clog2(TimeoutClocks + 1);

   typedef enum logic [2:0] {HUNT, LEN, PAYLOAD, CHECK, DRAIN} state_t;
   state_t state, state_next;

   logic [7:0]    len, idx, rd, sum;
   logic [7:0]    rd_inc, sum_chk;
   logic [TW-1:0] tcnt;
   logic [7:0]    mem [MaxPayload];
   logic          consume, xfer, timeout_hit, len_bad, sum_ok, err_set;
   logic [1:0]    err_code;

   // The done pulse itself blocks a second consume while the receiver still shows valid.
   assign consume     = rx_byte_valid_in && !rx_byte_done_out && (state != DRAIN);
   assign xfer        = out_valid && out_ready;
   assign timeout_hit = (tcnt == TW'(TimeoutClocks - 1));
   assign len_bad     = (rx_byte_in == 8'd0) || (rx_byte_in > 8'(MaxPayload));
   assign sum_chk     = sum + rx_byte_in;
   assign sum_ok      = (sum_chk == 8'd0);
   assign rd_inc      = rd + 8'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= HUNT;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      err_set    = 1'b0;
      err_code   = 2'd0;
      case (state)
         HUNT: if (consume && rx_byte_in == SyncByte) state_next = LEN;
         LEN: begin
            if (consume) begin
               if (len_bad) begin
                  state_next = HUNT;
                  err_set    = 1'b1;
                  err_code   = 2'd1;
               end else begin
                  state_next = PAYLOAD;
               end
            end else if (timeout_hit) begin
               state_next = HUNT;
               err_set    = 1'b1;
               err_code   = 2'd3;
            end
         end
         PAYLOAD: begin
            if (consume) begin
               if (idx == len - 8'd1) state_next = CHECK;
            end else if (timeout_hit) begin
               state_next = HUNT;
               err_set    = 1'b1;
               err_code   = 2'd3;
            end
         end
         CHECK: begin
            if (consume) begin
               if (sum_ok) begin
                  state_next = DRAIN;
               end else begin
                  state_next = HUNT;
                  err_set    = 1'b1;
                  err_code   = 2'd2;
               end
            end else if (timeout_hit) begin
               state_next = HUNT;
               err_set    = 1'b1;
               err_code   = 2'd3;
            end
         end
         DRAIN:   if (xfer && out_last) state_next = HUNT;
         default: state_next = HUNT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_byte_done_out <= 1'b0;
         frame_ok_out     <= 1'b0;
         frame_error_out  <= 1'b0;
         error_code_out   <= 2'd0;
         busy_out         <= 1'b0;
         out_valid        <= 1'b0;
         out_byte         <= 8'd0;
         out_last         <= 1'b0;
         len              <= 8'd0;
         idx              <= 8'd0;
         rd               <= 8'd0;
         sum              <= 8'd0;
         tcnt             <= '0;
      end else begin
         rx_byte_done_out <= consume;
         frame_ok_out     <= (state == CHECK) && consume && sum_ok;
         frame_error_out  <= err_set;
         busy_out         <= (state_next != HUNT);
         if (err_set) error_code_out <= err_code;
         // A consumed byte wins over a timeout reached in the same cycle.
         if (consume || state == HUNT || state == DRAIN) tcnt <= '0;
         else                                            tcnt <= tcnt + 1'b1;
         case (state)
            LEN: if (consume && !len_bad) begin
               len <= rx_byte_in;
               idx <= 8'd0;
               sum <= rx_byte_in;
            end
            PAYLOAD: if (consume) begin
               idx <= idx + 8'd1;
               sum <= sum_chk;
            end
            CHECK: if (consume && sum_ok) begin
               out_valid <= 1'b1;
               out_byte  <= mem[0];
               out_last  <= (len == 8'd1);
               rd        <= 8'd0;
            end
            DRAIN: if (xfer) begin
               if (out_last) begin
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
               end else begin
                  rd       <= rd_inc;
                  out_byte <= mem[rd_inc[AW-1:0]];
                  out_last <= (rd_inc == len - 8'd1);
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (state == PAYLOAD && consume) mem[idx[AW-1:0]] <= rx_byte_in;
   end
endmodule
